// File: rtl/pipe_flow_ctrl_if.sv
// Flow-control bundle between hazard unit, fetch and the flow controller.
// Hazard/fetch side uses master, the controller uses slave.
interface pipe_flow_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
);
  logic              pc_stall_i;
  logic              if_flush_i;
  logic              id_flush_i;
  logic              ex_flush_i;
  logic              branch_taken_i;
  logic [ADDR_W-1:0] branch_target_i;
  logic [ADDR_W-1:0] instr_i;
  logic [ADDR_W-1:0] pc_o;
  logic [ADDR_W-1:0] if_id_pc_o;
  logic [ADDR_W-1:0] if_id_instr_o;
  logic              if_id_valid_o;
  logic              id_ex_valid_o;
  logic              ex_mem_valid_o;
  logic [1:0]        state_o;
  logic [CNT_W-1:0]  stall_cnt_o;
  logic [CNT_W-1:0]  flush_cnt_o;
  logic              stall_err_o;

  modport master (
    output pc_stall_i, if_flush_i, id_flush_i,
    output ex_flush_i, branch_taken_i,
    output branch_target_i, instr_i,
    input  pc_o, if_id_pc_o, if_id_instr_o,
    input  if_id_valid_o, id_ex_valid_o,
    input  ex_mem_valid_o, state_o,
    input  stall_cnt_o, flush_cnt_o, stall_err_o
  );

  modport slave (
    input  pc_stall_i, if_flush_i, id_flush_i,
    input  ex_flush_i, branch_taken_i,
    input  branch_target_i, instr_i,
    output pc_o, if_id_pc_o, if_id_instr_o,
    output if_id_valid_o, id_ex_valid_o,
    output ex_mem_valid_o, state_o,
    output stall_cnt_o, flush_cnt_o, stall_err_o
  );
endinterface

// File: rtl/pipe_flow_ctrl.sv
// Pipeline flow controller: PC, IF/ID, stage valids, stall/flush stats.
// Ports: clk_i, rst_i (async active-low), bus (pipe_flow_ctrl_if.slave).
module pipe_flow_ctrl #(
  parameter int              ADDR_W    = 32,
  parameter int              CNT_W     = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int              MAX_STALL = 8
) (
  input logic             clk_i,
  input logic             rst_i,
  pipe_flow_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    STALL    = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  localparam int RUN_W = $clog2(MAX_STALL + 1);
  localparam logic [RUN_W-1:0] RUN_MAX =
    RUN_W'(MAX_STALL);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc;
  logic [ADDR_W-1:0] ifpc_q, ifins_q;
  logic              ifv_q, idv_q, exv_q;
  logic [CNT_W-1:0]  scnt_q, fcnt_q;
  logic [RUN_W-1:0]  run_q, run_d;
  logic              err_q;
  logic              stall_hit, squash_if;
  logic              hold_if, any_flush;

  assign stall_hit = bus.pc_stall_i
                   && !bus.branch_taken_i;
  assign squash_if = bus.if_flush_i
                   || bus.branch_taken_i;
  assign hold_if   = bus.pc_stall_i && !squash_if;
  assign any_flush = bus.if_flush_i
                   || bus.id_flush_i
                   || bus.ex_flush_i
                   || bus.branch_taken_i;
  assign pc_inc    = pc_q + ADDR_W'(4);

  always_comb begin
    state_d = RUN;
    pc_d    = pc_inc;
    unique case (1'b1)
      bus.branch_taken_i: begin
        state_d = REDIRECT;
        pc_d    = bus.branch_target_i;
      end
      stall_hit: begin
        state_d = STALL;
        pc_d    = pc_q;
      end
      default: begin
        state_d = RUN;
        pc_d    = pc_inc;
      end
    endcase
  end

  // Run length saturates at MAX_STALL so it cannot wrap
  always_comb begin
    run_d = '0;
    if (stall_hit)
      run_d = (run_q == RUN_MAX) ? run_q
            : run_q + RUN_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      ifpc_q  <= '0;
      ifins_q <= '0;
      ifv_q   <= 1'b0;
      idv_q   <= 1'b0;
      exv_q   <= 1'b0;
      scnt_q  <= '0;
      fcnt_q  <= '0;
      run_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      unique case (1'b1)
        squash_if: begin
          ifins_q <= '0;
          ifv_q   <= 1'b0;
        end
        hold_if: ;
        default: begin
          ifins_q <= bus.instr_i;
          ifpc_q  <= pc_inc;
          ifv_q   <= 1'b1;
        end
      endcase
      idv_q <= bus.id_flush_i ? 1'b0 : ifv_q;
      exv_q <= bus.ex_flush_i ? 1'b0 : idv_q;
      if (stall_hit && !(&scnt_q))
        scnt_q <= scnt_q + CNT_W'(1);
      if (any_flush && !(&fcnt_q))
        fcnt_q <= fcnt_q + CNT_W'(1);
      run_q <= run_d;
      if (run_d == RUN_MAX)
        err_q <= 1'b1;
    end
  end

  assign bus.pc_o           = pc_q;
  assign bus.if_id_pc_o     = ifpc_q;
  assign bus.if_id_instr_o  = ifins_q;
  assign bus.if_id_valid_o  = ifv_q;
  assign bus.id_ex_valid_o  = idv_q;
  assign bus.ex_mem_valid_o = exv_q;
  assign bus.state_o        = state_q;
  assign bus.stall_cnt_o    = scnt_q;
  assign bus.flush_cnt_o    = fcnt_q;
  assign bus.stall_err_o    = err_q;

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// Testbench for pipe_flow_ctrl: vector table, corner sequences,
// and random traffic against a cycle reference model.
module tb_pipe_flow_ctrl;

  localparam int AW   = 32;
  localparam int CW   = 16;
  localparam int MAXS = 8;
  localparam int CMAX = (1 << CW) - 1;
  localparam logic [31:0] LW = 32'h8C01_0004;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipe_flow_ctrl_if #(.ADDR_W(AW), .CNT_W(CW)) bus ();

  pipe_flow_ctrl #(
    .ADDR_W(AW), .CNT_W(CW),
    .RESET_PC(32'h0), .MAX_STALL(MAXS)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_n),
    .bus(bus)
  );

  // reference model
  logic [31:0] m_pc, m_ifpc, m_ifins;
  logic        m_ifv, m_idv, m_exv, m_err;
  int          m_st, m_sc, m_fc, m_run;

  task automatic model_reset();
    m_pc = 0; m_ifpc = 0; m_ifins = 0;
    m_ifv = 0; m_idv = 0; m_exv = 0; m_err = 0;
    m_st = 0; m_sc = 0; m_fc = 0; m_run = 0;
  endtask

  task automatic model_step(
    input logic s, f1, f2, f3, b,
    input logic [31:0] tgt, ins
  );
    logic [31:0] seq;
    logic        nid, nex;
    seq = m_pc + 32'd4;
    nid = f2 ? 1'b0 : m_ifv;
    nex = f3 ? 1'b0 : m_idv;
    if (f1 || b) begin
      m_ifins = 0; m_ifv = 0;
    end else if (!s) begin
      m_ifins = ins; m_ifpc = seq; m_ifv = 1;
    end
    m_pc  = b ? tgt : (s ? m_pc : seq);
    m_idv = nid;
    m_exv = nex;
    m_st  = b ? 2 : (s ? 1 : 0);
    if (s && !b) begin
      if (m_sc < CMAX) m_sc++;
      m_run++;
    end else begin
      m_run = 0;
    end
    if ((f1 || f2 || f3 || b) && m_fc < CMAX)
      m_fc++;
    if (m_run >= MAXS) m_err = 1;
  endtask

  task automatic chk(
    input string nm,
    input logic [31:0] act, exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic check_all(input string t);
    chk({t, ".pc"}, bus.pc_o, m_pc);
    chk({t, ".ifpc"}, bus.if_id_pc_o, m_ifpc);
    chk({t, ".ifins"}, bus.if_id_instr_o, m_ifins);
    chk({t, ".ifv"}, 32'(bus.if_id_valid_o),
        32'(m_ifv));
    chk({t, ".idv"}, 32'(bus.id_ex_valid_o),
        32'(m_idv));
    chk({t, ".exv"}, 32'(bus.ex_mem_valid_o),
        32'(m_exv));
    chk({t, ".st"}, 32'(bus.state_o), 32'(m_st));
    chk({t, ".sc"}, 32'(bus.stall_cnt_o),
        32'(m_sc));
    chk({t, ".fc"}, 32'(bus.flush_cnt_o),
        32'(m_fc));
    chk({t, ".err"}, 32'(bus.stall_err_o),
        32'(m_err));
  endtask

  task automatic step(
    input string t,
    input logic s, f1, f2, f3, b,
    input logic [31:0] tgt, ins
  );
    bus.pc_stall_i      = s;
    bus.if_flush_i      = f1;
    bus.id_flush_i      = f2;
    bus.ex_flush_i      = f3;
    bus.branch_taken_i  = b;
    bus.branch_target_i = tgt;
    bus.instr_i         = ins;
    @(posedge clk);
    model_step(s, f1, f2, f3, b, tgt, ins);
    #1;
    check_all(t);
  endtask

  task automatic idle(input string t);
    step(t, 0, 0, 0, 0, 0, 32'h0, LW);
  endtask

  // asserted mid-cycle to exercise the async path
  task automatic do_reset(input string t);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all({t, ".async"});
    @(posedge clk);
    #1;
    check_all({t, ".held"});
    rst_n = 1'b1;
    bus.pc_stall_i     = 0;
    bus.if_flush_i     = 0;
    bus.id_flush_i     = 0;
    bus.ex_flush_i     = 0;
    bus.branch_taken_i = 0;
  endtask

  typedef struct {
    logic        s, f1, f2, f3, b;
    logic [31:0] tgt;
    logic [31:0] pc;
    logic        ifv, idv, exv;
    logic [1:0]  st;
    int          sc, fc;
  } vec_t;

  vec_t tbl[13];

  initial begin
    tbl[0]  = '{0,0,0,0,0, 0, 32'h04, 1,0,0, 0, 0,0};
    tbl[1]  = '{0,0,0,0,0, 0, 32'h08, 1,1,0, 0, 0,0};
    tbl[2]  = '{0,0,0,0,0, 0, 32'h0C, 1,1,1, 0, 0,0};
    tbl[3]  = '{0,0,0,0,0, 0, 32'h10, 1,1,1, 0, 0,0};
    tbl[4]  = '{1,0,1,0,0, 0, 32'h10, 1,0,1, 1, 1,1};
    tbl[5]  = '{0,0,0,0,0, 0, 32'h14, 1,1,0, 0, 1,1};
    tbl[6]  = '{1,0,0,0,1, 32'h40,
                32'h40, 0,1,1, 2, 1,2};
    tbl[7]  = '{0,0,0,0,0, 0, 32'h44, 1,0,1, 0, 1,2};
    tbl[8]  = '{0,0,0,0,0, 0, 32'h48, 1,1,0, 0, 1,2};
    tbl[9]  = '{0,0,0,1,0, 0, 32'h4C, 1,1,0, 0, 1,3};
    tbl[10] = '{0,0,0,0,0, 0, 32'h50, 1,1,1, 0, 1,3};
    tbl[11] = '{0,1,0,0,0, 0, 32'h54, 0,1,1, 0, 1,4};
    tbl[12] = '{0,0,0,0,0, 0, 32'h58, 1,0,1, 0, 1,4};

    rst_n = 1'b0;
    bus.pc_stall_i      = 0;
    bus.if_flush_i      = 0;
    bus.id_flush_i      = 0;
    bus.ex_flush_i      = 0;
    bus.branch_taken_i  = 0;
    bus.branch_target_i = 0;
    bus.instr_i         = LW;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("por");
    chk("por.pc", bus.pc_o, 32'h0);
    rst_n = 1'b1;

    // vector table from reset release
    for (int i = 0; i < 13; i++) begin
      step($sformatf("tbl%0d", i),
           tbl[i].s, tbl[i].f1, tbl[i].f2,
           tbl[i].f3, tbl[i].b, tbl[i].tgt, LW);
      chk("tbl.pc", bus.pc_o, tbl[i].pc);
      chk("tbl.ifv", 32'(bus.if_id_valid_o),
          32'(tbl[i].ifv));
      chk("tbl.idv", 32'(bus.id_ex_valid_o),
          32'(tbl[i].idv));
      chk("tbl.exv", 32'(bus.ex_mem_valid_o),
          32'(tbl[i].exv));
      chk("tbl.st", 32'(bus.state_o),
          32'(tbl[i].st));
      chk("tbl.sc", 32'(bus.stall_cnt_o),
          32'(tbl[i].sc));
      chk("tbl.fc", 32'(bus.flush_cnt_o),
          32'(tbl[i].fc));
      if (i == 0) begin
        chk("first.ins", bus.if_id_instr_o, LW);
        chk("first.ifpc", bus.if_id_pc_o, 32'h4);
      end
    end

    // watchdog: 7 stalls no flag, 8 stalls flag
    do_reset("wd");
    for (int i = 0; i < 7; i++)
      step("wd7", 1, 0, 0, 0, 0, 0, LW);
    idle("wd7r");
    chk("wd7.err", 32'(bus.stall_err_o), 32'h0);
    for (int i = 0; i < 8; i++)
      step("wd8", 1, 0, 0, 0, 0, 0, LW);
    chk("wd8.err", 32'(bus.stall_err_o), 32'h1);
    idle("wd8r");
    idle("wd8r");
    chk("wd8.sticky", 32'(bus.stall_err_o), 32'h1);

    // ex flush bubble lasts one cycle
    do_reset("exf");
    repeat (3) idle("exf.fill");
    step("exf.p", 0, 0, 0, 1, 0, 0, LW);
    chk("exf.lo", 32'(bus.ex_mem_valid_o), 32'h0);
    idle("exf.n");
    chk("exf.hi", 32'(bus.ex_mem_valid_o), 32'h1);

    // reset mid-stall at pc 0x24
    do_reset("ms");
    repeat (9) idle("ms.run");
    chk("ms.pc", bus.pc_o, 32'h24);
    step("ms.st", 1, 0, 1, 0, 0, 0, LW);
    step("ms.st", 1, 0, 0, 0, 0, 0, LW);
    chk("ms.state", 32'(bus.state_o), 32'h1);
    do_reset("ms.rst");
    chk("ms.rpc", bus.pc_o, 32'h0);
    chk("ms.rsc", 32'(bus.stall_cnt_o), 32'h0);

    // PC wraps at top of address space
    step("wrap.b", 0, 0, 0, 0, 1,
         32'hFFFF_FFFC, LW);
    chk("wrap.top", bus.pc_o, 32'hFFFF_FFFC);
    idle("wrap.n");
    chk("wrap.zero", bus.pc_o, 32'h0);

    // randomized traffic against the model
    do_reset("rnd");
    for (int i = 0; i < 400; i++) begin
      logic s, f1, f2, f3, b;
      s  = ($urandom % 4) == 0;
      f1 = ($urandom % 8) == 0;
      f2 = s ? 1'($urandom % 2)
             : (($urandom % 8) == 0);
      f3 = ($urandom % 8) == 0;
      b  = ($urandom % 10) == 0;
      step("rnd", s, f1, f2, f3, b,
           $urandom & 32'hFFFF_FFFC, $urandom);
      if (i == 200) do_reset("rnd.mid");
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_flow_ctrl.md
# pipe_flow_ctrl

Pipeline flow controller that acts on the stall/flush requests issued by the hazard detection unit. It owns the fetch PC register, the IF/ID instruction register and the valid bits of the ID/EX and EX/MEM stages. It turns PC_Stall/IF_Flush/ID_Flush/EX_Flush and branch redirects into register holds and bubble insertion. It also keeps saturating stall/flush statistics and a stall watchdog. It sits between the instruction memory, the hazard detection unit and the ID/EX pipeline register of the 5-stage MIPS core.

## Interface
- ADDR_W, 32, PC and instruction width
- CNT_W, 16, width of statistics counters
- RESET_PC, 32'h0000_0000, PC value after reset
- MAX_STALL, 8, consecutive stall cycles tolerated before stall_err_o
- clk_i  input  1  clock, all state updates on rising edge
- rst_i  input  1  asynchronous, active-low reset
- pc_stall_i  input  1  hold PC and IF/ID (load-use)
- if_flush_i  input  1  squash IF/ID contents
- id_flush_i  input  1  insert bubble into ID/EX
- ex_flush_i  input  1  insert bubble into EX/MEM
- branch_taken_i  input  1  redirect fetch this cycle
- branch_target_i  input  ADDR_W  redirect address
- instr_i  input  ADDR_W  instruction read at pc_o
- pc_o  output  ADDR_W  current fetch PC
- if_id_pc_o  output  ADDR_W  PC+4 of instruction in IF/ID
- if_id_instr_o  output  ADDR_W  instruction in IF/ID (0 = NOP when invalid)
- if_id_valid_o  output  1  IF/ID holds a live instruction
- id_ex_valid_o  output  1  ID/EX live (0 = bubble, control zeroed downstream)
- ex_mem_valid_o  output  1  EX/MEM live
- state_o  output  2  FSM state (RUN=0, STALL=1, REDIRECT=2)
- stall_cnt_o  output  CNT_W  total stall cycles, saturating
- flush_cnt_o  output  CNT_W  total cycles with any flush or redirect, saturating
- stall_err_o  output  1  sticky watchdog flag

## Operation
- PC next, in priority order:
  - branch_taken_i → branch_target_i
  - pc_stall_i → hold
  - otherwise → pc_o+4, modulo 2^ADDR_W, wraps silently.
- IF/ID:
  - if_flush_i or branch_taken_i → instr=0, valid=0, pc held.
  - Else pc_stall_i → hold all fields.
  - Else load instr_i, pc_o+4, valid=1.
- id_ex_valid next: id_flush_i → 0; else if_id_valid_o. A stall without id_flush_i still forwards if_id_valid_o (the hazard unit pairs stall with ID flush for load-use).
- ex_mem_valid next: ex_flush_i → 0; else id_ex_valid_o.
- Flush always beats stall on the same register; branch beats stall on PC.
- FSM:
  - RUN → STALL on pc_stall_i && !branch_taken_i.
  - Any state → REDIRECT on branch_taken_i.
  - STALL → RUN when pc_stall_i drops.
  - REDIRECT → RUN next cycle, or STALL if pc_stall_i && !branch_taken_i.
- Consecutive-stall counter:
  - Increments each cycle in STALL with pc_stall_i high; clears otherwise.
  - Reaching MAX_STALL sets stall_err_o, which stays set until reset.
  - Stall behaviour is unaffected by the flag.
- stall_cnt_o increments on every cycle with pc_stall_i && !branch_taken_i.
- flush_cnt_o increments on any of if/id/ex flush or branch_taken_i.
- Both counters saturate at all-ones.

## Timing
- All outputs are registered; requests sampled at edge N take effect on outputs after edge N.
- Redirect latency 1 cycle: pc_o = target after the edge where branch_taken_i was high.
- Reset (rst_i low, asynchronous, any time including mid-stall):
  - pc_o=RESET_PC.
  - if_id_instr_o=0, if_id_pc_o=0.
  - All valids=0, state_o=RUN, counters=0, stall_err_o=0.
- First live IF/ID instruction appears one edge after rst_i release.

## Test plan
- Reset release, instr_i=0x8C01_0004 → pc_o 0,4,8…; after edge 1 if_id_instr_o=0x8C01_0004, if_id_valid_o=1, if_id_pc_o=4.
- pc_stall_i+id_flush_i for 1 cycle at pc_o=0x10 → pc_o stays 0x10, IF/ID held, id_ex_valid_o=0 next cycle, stall_cnt_o=1, state STALL then RUN.
- branch_taken_i with pc_stall_i simultaneously, target 0x40 → pc_o=0x40, if_id_valid_o=0, state REDIRECT, stall_cnt_o unchanged, flush_cnt_o+1.
- pc_stall_i held 8 cycles (MAX_STALL=8) → stall_err_o=1 and stays after stall drops; held 7 → stays 0.
- ex_flush_i pulse with id_ex_valid_o=1 → ex_mem_valid_o=0 for exactly one cycle.
- rst_i asserted mid-stall at pc_o=0x24 → immediate RESET_PC, valids 0, counters 0; pc_o=0xFFFF_FFFC wraps to 0.
